// File: rtl/eeprom_boot_loader.sv
// Program-load sequencer for the EEPROM/RAM block.
// In IDLE the CPU owns the memory port (pass-through). On an accepted start the loader
// takes the port, writes a valid/ready byte stream into cells 0..len-1, reads the image
// back, compares it against the running checksum, then returns the port to the CPU.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, abort, len               load request, cancel, byte count (1..DEPTH)
//   in_data, in_valid, in_ready     byte stream handshake
//   cpu_addr/data/ram_in/ram_out    CPU side of the memory port
//   mem_addr/data/ram_in/ram_out    to the EEPROM block
//   mem_q                           combinational EEPROM read data of mem_addr
//   busy, done, error, checksum     status; done/error are sticky until next start
module eeprom_boot_loader #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   len,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data,
   input  logic              cpu_ram_in,
   input  logic              cpu_ram_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_ram_in,
   output logic              mem_ram_out,
   input  logic [7:0]        mem_q,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        checksum
);

   typedef enum logic [1:0] {StIdle, StLoad, StVerify} state_e;

   localparam logic [ADDR_W:0] CntOne   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);

   state_e          state;
   logic [ADDR_W:0] cnt;
   logic [ADDR_W:0] len_q;
   logic [7:0]      sum;
   logic [7:0]      vsum;

   logic            last;
   logic            accept;
   logic            len_ok;
   logic [7:0]      vsum_next;

   assign last      = (cnt == len_q - CntOne);
   // abort wins over a same-cycle handshake: the byte is neither accepted nor written
   assign accept    = (state == StLoad) && in_valid && !abort;
   assign len_ok    = (len != '0) && (len <= DepthLen);
   assign vsum_next = vsum + mem_q;

   assign busy      = (state != StIdle);
   assign in_ready  = (state == StLoad);
   assign checksum  = sum;

   // Memory port mux; CPU inputs are ignored entirely while busy.
   always_comb begin
      mem_addr    = cpu_addr;
      mem_data    = cpu_data;
      mem_ram_in  = cpu_ram_in;
      mem_ram_out = cpu_ram_out;
      case (state)
         StLoad: begin
            mem_addr    = cnt[ADDR_W-1:0];
            mem_data    = in_data;
            mem_ram_in  = accept;
            mem_ram_out = 1'b0;
         end
         StVerify: begin
            mem_addr    = cnt[ADDR_W-1:0];
            mem_data    = 8'h00;
            mem_ram_in  = 1'b0;
            mem_ram_out = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
         cnt   <= '0;
         len_q <= '0;
         sum   <= '0;
         vsum  <= '0;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  done <= 1'b0;
                  if (len_ok) begin
                     len_q <= len;
                     cnt   <= '0;
                     sum   <= '0;
                     error <= 1'b0;
                     state <= StLoad;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (abort) begin
                  error <= 1'b1;
                  state <= StIdle;
               end else if (accept) begin
                  sum <= sum + in_data;
                  if (last) begin
                     cnt   <= '0;
                     vsum  <= '0;
                     state <= StVerify;
                  end else begin
                     cnt <= cnt + CntOne;
                  end
               end
            end
            StVerify: begin
               if (abort) begin
                  error <= 1'b1;
                  state <= StIdle;
               end else begin
                  vsum <= vsum_next;
                  cnt  <= cnt + CntOne;
                  if (last) begin
                     if (vsum_next == sum) done  <= 1'b1;
                     else                  error <= 1'b1;
                     state <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// Self-checking bench for eeprom_boot_loader: table of directed vectors plus random
// transactions, each checked against a byte-level model of the load/verify rules, and a
// few hand-written sequences (reset, pass-through, bad len, CPU write, mid-load reset).
module tb_eeprom_boot_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
   localparam int BUDGET = 4096;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W:0]   len = '0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [7:0]        cpu_data = '0;
   logic              cpu_ram_in = 1'b0;
   logic              cpu_ram_out = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_ram_in;
   logic              mem_ram_out;
   logic [7:0]        mem_q;
   logic              busy;
   logic              done;
   logic              error;
   logic [7:0]        checksum;

   always #5 clk = ~clk;

   eeprom_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ram_in(cpu_ram_in),
      .cpu_ram_out(cpu_ram_out), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ram_in(mem_ram_in), .mem_ram_out(mem_ram_out), .mem_q(mem_q),
      .busy(busy), .done(done), .error(error), .checksum(checksum)
   );

   // EEPROM model: synchronous write, combinational read, optional read corruption.
   logic [7:0] mem [DEPTH];
   logic [7:0] exp_mem [DEPTH];
   logic       corrupt_now = 1'b0;
   int         wr_count = 0;
   int         last_wr_addr = -1;

   assign mem_q = corrupt_now ? 8'h00 : mem[mem_addr];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 7 + 8'h5A);
      forever begin
         @(posedge clk);
         if (mem_ram_in) begin
            mem[mem_addr] <= mem_data;
            wr_count      <= wr_count + 1;
            last_wr_addr  <= int'(mem_addr);
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   typedef struct {
      int len;
      int pat;          // 0: 0x11*(i+1), 1: all 0xFF, 2: random
      int gap;          // 0: valid always, 1: valid on odd LOAD cycles, 2: random
      int abort_after;  // abort when this many bytes accepted, -1 none
      int corrupt_at;   // VERIFY cycle forced to read 0x00, -1 none
      bit cpu_wr;       // CPU tries to write cell 900 while busy
      int exp_sum;      // -1: constant not given
      int exp_done;
      int exp_err;
      int exp_load;
      int exp_verify;
   } vec_t;

   logic [7:0] bytes [DEPTH];
   bit         vpat  [BUDGET];

   task automatic apply_vec(input vec_t v, input string tag);
      int m_acc, m_sum, m_vs, m_load, m_verify, ones, c, idx, lc, vc, wr0;
      bit m_done;
      bit bad;
      // stimulus
      for (int i = 0; i < v.len; i++)
         bytes[i] = (v.pat == 0) ? 8'(8'h11 * (i + 1)) :
                    (v.pat == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      for (int i = 0; i < BUDGET; i++)
         vpat[i] = (v.gap == 0) ? 1'b1 : (v.gap == 1) ? i[0] : 1'($urandom_range(0, 1));
      // reference model
      m_acc = (v.abort_after >= 0) ? v.abort_after : v.len;
      m_sum = 0;
      for (int i = 0; i < m_acc; i++) m_sum = (m_sum + bytes[i]) % 256;
      ones = 0; c = 0;
      while (ones < m_acc && c < BUDGET) begin
         if (vpat[c]) ones++;
         c++;
      end
      m_load   = (v.abort_after >= 0) ? c + 1 : c;
      m_verify = (v.abort_after >= 0) ? 0 : v.len;
      m_vs = 0;
      for (int i = 0; i < v.len; i++) if (i != v.corrupt_at) m_vs = (m_vs + bytes[i]) % 256;
      m_done = (v.abort_after < 0) && (m_vs == m_sum);
      for (int i = 0; i < m_acc; i++) exp_mem[i] = bytes[i];
      // drive
      wr0 = wr_count;
      @(negedge clk);
      len   = (ADDR_W+1)'(v.len);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy after start"}, busy, 1);
      if (v.cpu_wr) begin
         cpu_addr = 10'd900; cpu_data = 8'hC3; cpu_ram_in = 1'b1;
      end
      idx = 0; lc = 0;
      while (in_ready && lc < BUDGET) begin
         if (v.abort_after >= 0 && idx == v.abort_after) begin
            abort = 1'b1; in_valid = 1'b1;
         end else begin
            abort = 1'b0; in_valid = vpat[lc];
         end
         in_data = bytes[idx % DEPTH];
         @(negedge clk);
         if (in_valid && !abort) idx++;
         lc++;
      end
      abort = 1'b0; in_valid = 1'b0;
      vc = 0;
      while (busy && vc < BUDGET) begin
         corrupt_now = (vc == v.corrupt_at);
         @(negedge clk);
         vc++;
      end
      corrupt_now = 1'b0; cpu_ram_in = 1'b0;
      // compare against model
      check({tag, " checksum"}, checksum, m_sum);
      check({tag, " done"}, done, m_done);
      check({tag, " error"}, error, !m_done);
      check({tag, " busy after end"}, busy, 0);
      check({tag, " load cycles"}, lc, m_load);
      check({tag, " verify cycles"}, vc, m_verify);
      check({tag, " write count"}, wr_count - wr0, m_acc);
      if (m_acc > 0) check({tag, " last write addr"}, last_wr_addr, m_acc - 1);
      bad = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!bad && mem[i] !== exp_mem[i]) begin
            bad = 1'b1;
            check($sformatf("%s mem[%0d]", tag, i), mem[i], exp_mem[i]);
         end
      end
      if (!bad) check({tag, " mem image"}, 0, 0);
      // constants from the directed table
      if (v.exp_sum    >= 0) check({tag, " const checksum"}, checksum, v.exp_sum);
      if (v.exp_done   >= 0) check({tag, " const done"}, done, v.exp_done);
      if (v.exp_err    >= 0) check({tag, " const error"}, error, v.exp_err);
      if (v.exp_load   >= 0) check({tag, " const load"}, lc, v.exp_load);
      if (v.exp_verify >= 0) check({tag, " const verify"}, vc, v.exp_verify);
   endtask

   vec_t tbl [6];

   initial begin
      int wr0;
      vec_t r;
      tbl[0] = '{4, 0, 0, -1, -1, 0, 8'hAA, 1, 0, 4, 4};
      tbl[1] = '{4, 0, 1, -1, -1, 0, 8'hAA, 1, 0, 8, 4};
      tbl[2] = '{4, 0, 0, -1,  2, 0, 8'hAA, 0, 1, 4, 4};
      tbl[3] = '{3, 0, 2, -1, -1, 1, 8'h66, 1, 0, -1, 3};
      tbl[4] = '{DEPTH, 1, 0, -1, -1, 0, 8'h00, 1, 0, DEPTH, DEPTH};
      tbl[5] = '{5, 0, 0,  2, -1, 0, 8'h33, 0, 1, 3, 0};
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'(i * 7 + 8'h5A);

      // reset state and IDLE pass-through
      @(negedge clk);
      check("reset busy", busy, 0);
      check("reset in_ready", in_ready, 0);
      check("reset done", done, 0);
      check("reset error", error, 0);
      check("reset checksum", checksum, 0);
      cpu_addr = 10'd5; cpu_data = 8'h77; cpu_ram_in = 1'b1; cpu_ram_out = 1'b1;
      #1;
      check("pass addr", mem_addr, 5);
      check("pass data", mem_data, 8'h77);
      check("pass ram_in", mem_ram_in, 1);
      check("pass ram_out", mem_ram_out, 1);
      cpu_ram_in = 1'b0; cpu_ram_out = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 6; k++) apply_vec(tbl[k], $sformatf("v%0d", k));

      // after an abort the CPU owns the port again
      @(negedge clk);
      cpu_addr = 10'd7; cpu_data = 8'h5C; cpu_ram_in = 1'b1;
      @(negedge clk);
      cpu_ram_in = 1'b0; cpu_ram_out = 1'b1;
      exp_mem[7] = 8'h5C;
      #1;
      check("cpu write 7", mem[7], 8'h5C);
      check("cpu read 7", mem_q, 8'h5C);
      check("cpu read ram_out", mem_ram_out, 1);
      cpu_ram_out = 1'b0;

      // bad lengths: error, never busy, no write pulse
      foreach (tbl[k]) if (k == 0) apply_vec(tbl[0], "pre-bad");
      for (int b = 0; b < 2; b++) begin
         wr0 = wr_count;
         @(negedge clk);
         len = (b == 0) ? '0 : (ADDR_W+1)'(DEPTH + 1);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check($sformatf("badlen%0d error", b), error, 1);
         check($sformatf("badlen%0d done", b), done, 0);
         check($sformatf("badlen%0d busy", b), busy, 0);
         repeat (3) @(negedge clk);
         check($sformatf("badlen%0d busy later", b), busy, 0);
         check($sformatf("badlen%0d writes", b), wr_count - wr0, 0);
      end

      // random transactions against the model
      for (int k = 0; k < 24; k++) begin
         r.len = $urandom_range(1, 40);
         r.pat = 2;
         r.gap = $urandom_range(0, 2);
         r.abort_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r.len - 1)) : -1;
         r.corrupt_at = (r.abort_after < 0 && $urandom_range(0, 2) == 0) ?
                        int'($urandom_range(0, r.len - 1)) : -1;
         r.cpu_wr = 1'($urandom_range(0, 1));
         r.exp_sum = -1; r.exp_done = -1; r.exp_err = -1; r.exp_load = -1; r.exp_verify = -1;
         apply_vec(r, $sformatf("rnd%0d", k));
      end

      // asynchronous reset in the middle of a full-depth load
      @(negedge clk);
      len = (ADDR_W+1)'(DEPTH); start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
      repeat (10) @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midreset busy", busy, 0);
      check("midreset in_ready", in_ready, 0);
      check("midreset done", done, 0);
      check("midreset error", error, 0);
      check("midreset checksum", checksum, 0);
      check("midreset cell 9 kept", mem[9], 8'h3C);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
